// File: rtl/ft232h_tx_sched.sv
// ft232h_tx_sched: round-robin packet scheduler that shares the FT232H USB
// transmit path between NUM_SRC byte-stream sources. Each granted packet is
// emitted as Avalon-MM writes of {HDR_TAG,ch}, len, payload bytes [, checksum]
// to the ft232h write-data register at ADDR_WR, honouring avm_waitrequest.
// Optional feature: define FT232H_TX_CSUM_EN to append an 8-bit checksum
// (sum mod 256 of len and all payload bytes) after the payload.
module ft232h_tx_sched #(
    parameter int          NUM_SRC = 2,
    parameter logic [7:0]  ADDR_WR = 8'd1,
    parameter logic [3:0]  HDR_TAG = 4'hA
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic [8*NUM_SRC-1:0]   src_len,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [8*NUM_SRC-1:0]   src_data,
    output logic [NUM_SRC-1:0]     src_ready,
    output logic [NUM_SRC-1:0]     src_grant,
    output logic [NUM_SRC-1:0]     src_done,
    output logic [7:0]             avm_address,
    output logic                   avm_write,
    output logic [31:0]            avm_writedata,
    input  logic                   avm_waitrequest
);

    localparam int CH_W = 2;

`ifdef FT232H_TX_CSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA} state_t;
`endif

    state_t               state_q;
    logic [CH_W-1:0]      ch_q;
    logic [CH_W-1:0]      rr_q;
    logic [7:0]           len_q;
    logic [8:0]           cnt_in_q;
    logic [8:0]           cnt_out_q;
    logic [NUM_SRC-1:0]   grant_q;
    // Output byte register: it carries the header bytes and doubles as the
    // one-byte payload hold register; vld_p1 is the Avalon write strobe.
    logic [7:0]           hold_p1;
    logic                 vld_p1;
`ifdef FT232H_TX_CSUM_EN
    logic [7:0]           csum_q;
`endif

    logic                 sent;
    logic                 take_ok;
    logic                 accept;
    logic [7:0]           in_byte;
    logic                 last_pay;
    logic                 done_now;
    logic                 pick_v;
    logic [CH_W-1:0]      pick_ch;
    logic [7:0]           pick_len;
    logic [CH_W-1:0]      rr_next;

    // First requester at or after the round-robin pointer; MSB flags a hit.
    // Scanning from the far end lets the nearest requester win last.
    function automatic logic [CH_W:0] pick_src(input logic [NUM_SRC-1:0] req,
                                               input logic [CH_W-1:0]    rr);
        logic [CH_W:0] r;
        int            c;
        r = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            c = (int'(rr) + i) % NUM_SRC;
            if (|(req & (NUM_SRC'(1) << c)))
                r = {1'b1, CH_W'(c)};
        end
        return r;
    endfunction

    // Arbitration, source muxing and the Avalon handshake terms.
    always_comb begin
        {pick_v, pick_ch} = pick_src(src_req, rr_q);
        pick_len = 8'h00;
        in_byte  = 8'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pick_ch == CH_W'(i))
                pick_len = src_len[i*8 +: 8];
            if (ch_q == CH_W'(i))
                in_byte = src_data[i*8 +: 8];
        end
        sent     = vld_p1 & ~avm_waitrequest;
        // Payload can be fetched once the header is leaving (HDR1) so the
        // first payload byte follows the length byte without a gap.
        take_ok  = ((state_q == S_HDR1) || (state_q == S_DATA)) &&
                   (~vld_p1 || sent) && (cnt_in_q <= {1'b0, len_q});
        accept   = take_ok && (|(src_valid & grant_q));
        last_pay = (cnt_out_q == {1'b0, len_q});
`ifdef FT232H_TX_CSUM_EN
        done_now = sent && (state_q == S_CSUM);
`else
        done_now = sent && (state_q == S_DATA) && last_pay;
`endif
        rr_next  = (ch_q == CH_W'(NUM_SRC - 1)) ? '0 : ch_q + 1'b1;
    end

    // Outputs: ready/done qualify the registered grant; address and data are
    // forced to zero whenever no write is pending.
    always_comb begin
        src_ready     = take_ok ? grant_q : '0;
        src_done      = done_now ? grant_q : '0;
        src_grant     = grant_q;
        avm_write     = vld_p1;
        avm_address   = vld_p1 ? ADDR_WR : 8'h00;
        avm_writedata = vld_p1 ? {24'h0, hold_p1} : 32'h0;
    end

    // Packet FSM: IDLE -> HDR0 -> HDR1 -> DATA [-> CSUM] -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            rr_q      <= '0;
            len_q     <= '0;
            cnt_in_q  <= '0;
            cnt_out_q <= '0;
            grant_q   <= '0;
            hold_p1   <= '0;
            vld_p1    <= 1'b0;
`ifdef FT232H_TX_CSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            // Payload intake into the hold register; a send with nothing to
            // refill it drops the write strobe.
            if (accept) begin
                hold_p1  <= in_byte;
                vld_p1   <= 1'b1;
                cnt_in_q <= cnt_in_q + 9'd1;
`ifdef FT232H_TX_CSUM_EN
                csum_q   <= csum_q + in_byte;
`endif
            end else if (sent && ((state_q == S_HDR1) || (state_q == S_DATA))) begin
                vld_p1 <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (pick_v) begin
                        state_q   <= S_HDR0;
                        ch_q      <= pick_ch;
                        len_q     <= pick_len;
                        grant_q   <= NUM_SRC'(1) << pick_ch;
                        cnt_in_q  <= '0;
                        cnt_out_q <= '0;
                        hold_p1   <= {HDR_TAG, {(4-CH_W){1'b0}}, pick_ch};
                        vld_p1    <= 1'b1;
`ifdef FT232H_TX_CSUM_EN
                        csum_q    <= pick_len;
`endif
                    end
                end
                S_HDR0: begin
                    if (sent) begin
                        hold_p1 <= len_q;
                        state_q <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (sent) begin
                        state_q   <= S_DATA;
                        cnt_out_q <= '0;
                    end
                end
                S_DATA: begin
                    if (sent) begin
                        if (last_pay) begin
`ifdef FT232H_TX_CSUM_EN
                            state_q <= S_CSUM;
                            hold_p1 <= csum_q;
                            vld_p1  <= 1'b1;
`else
                            state_q <= S_IDLE;
                            grant_q <= '0;
                            rr_q    <= rr_next;
                            vld_p1  <= 1'b0;
`endif
                        end else begin
                            cnt_out_q <= cnt_out_q + 9'd1;
                        end
                    end
                end
`ifdef FT232H_TX_CSUM_EN
                S_CSUM: begin
                    if (sent) begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                        rr_q    <= rr_next;
                        vld_p1  <= 1'b0;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ft232h_tx_sched.sv
// Testbench for ft232h_tx_sched: randomized sources and waitrequest checked
// against a packet-level reference model (round-robin pick, expected byte
// stream per packet, done on final byte).
module tb_ft232h_tx_sched;
    localparam int N = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      src_req = '0;
    logic [8*N-1:0]    src_len = '0;
    logic [N-1:0]      src_valid = '0;
    logic [8*N-1:0]    src_data = '0;
    logic [N-1:0]      src_ready;
    logic [N-1:0]      src_grant;
    logic [N-1:0]      src_done;
    logic [7:0]        avm_address;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest = 1'b0;

    ft232h_tx_sched #(.NUM_SRC(N), .ADDR_WR(8'd1), .HDR_TAG(4'hA)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_req(src_req), .src_len(src_len), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .src_grant(src_grant), .src_done(src_done),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    // source / environment state
    bit          pend [N];
    int          len_m [N];
    int          idx [N];
    logic [7:0]  pay [N][256];
    int          wait_pct = 0, valid_pct = 100, new_pct = 0;
    bit          auto_new = 0, nostall = 0, drop_en = 0;
    bit          stall_arm = 0, vgap_arm = 0;
    int          stall_cnt = 0, vgap_cnt = 0;

    // reference model state
    logic [7:0]  exp_q [$];
    int          order_q [$];
    bit          active = 0, prev_idle = 0, prev_wr = 0, prev_wait = 0;
    int          pkt_ch = 0, start_cyc = 0, pos = 0, rr_m = 0, cyc = 0, npk = 0;
    logic [N-1:0] req_prev = '0;
    logic [7:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;

    int          nvec = 0, nerr = 0;

    // monitor scratch
    logic [N-1:0] m_exp_g, m_exp_d;
    int           m_pick;
    bit           m_found, m_sent, m_cur_idle;
    logic [7:0]   m_b, m_cs;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic start_pkt(input int s, input int l);
        len_m[s] = l;
        for (int k = 0; k <= l; k++) pay[s][k] = 8'($urandom);
        idx[s]  = 0;
        pend[s] = 1;
    endtask

    function automatic bit any_pend();
        bit r = 0;
        for (int s = 0; s < N; s++) r |= pend[s];
        return r;
    endfunction

    task automatic wait_pk(input int target, input int budget);
        int n = 0;
        while (npk < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        check_val("pkt_timeout", 32'(npk >= target), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_write"}, avm_write, 0);
        check_val({tag, "_addr"}, avm_address, 0);
        check_val({tag, "_wdata"}, avm_writedata, 0);
        check_val({tag, "_grant"}, src_grant, 0);
        check_val({tag, "_done"}, src_done, 0);
        check_val({tag, "_ready"}, src_ready, 0);
    endtask

    // Source and slave driver: updates inputs 1 time unit after each rising edge.
    initial begin
        for (int s = 0; s < N; s++) begin pend[s] = 0; len_m[s] = 0; idx[s] = 0; end
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < N; s++) begin
                if (auto_new && !pend[s] && $urandom_range(0, 99) < new_pct)
                    start_pkt(s, ($urandom_range(0, 99) < 4) ? 255 : $urandom_range(0, 12));
                src_req[s] = pend[s] && !(drop_en && src_grant[s] && $urandom_range(0, 1) == 1);
                src_len[s*8 +: 8] = (drop_en && src_grant[s] && $urandom_range(0, 1) == 1)
                                    ? 8'($urandom) : 8'(len_m[s]);
                src_valid[s] = pend[s] && ($urandom_range(0, 99) < valid_pct) && (vgap_cnt == 0);
                src_data[s*8 +: 8] = (idx[s] <= len_m[s]) ? pay[s][idx[s]] : 8'hEE;
            end
            if (vgap_cnt > 0) vgap_cnt--;
            if (stall_cnt > 0) begin
                avm_waitrequest = 1'b1;
                stall_cnt--;
            end else begin
                avm_waitrequest = ($urandom_range(0, 99) < wait_pct);
            end
        end
    end

    // Reference model / monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            active = 0; rr_m = 0; prev_idle = 0; prev_wr = 0; prev_wait = 0;
            stall_cnt = 0; vgap_cnt = 0;
        end else begin
            cyc++;
            m_exp_g = '0;
            if (prev_idle && req_prev != '0) begin
                m_found = 0; m_pick = 0;
                for (int i = 0; i < N; i++) begin
                    if (!m_found && req_prev[(rr_m + i) % N]) begin
                        m_found = 1;
                        m_pick  = (rr_m + i) % N;
                    end
                end
                active = 1; pkt_ch = m_pick; start_cyc = cyc; pos = 0;
                order_q.push_back(m_pick);
                exp_q.delete();
                exp_q.push_back({4'hA, 4'(m_pick)});
                exp_q.push_back(8'(len_m[m_pick]));
                m_cs = 8'(len_m[m_pick]);
                for (int k = 0; k <= len_m[m_pick]; k++) begin
                    exp_q.push_back(pay[m_pick][k]);
                    m_cs = m_cs + pay[m_pick][k];
                end
`ifdef FT232H_TX_CSUM_EN
                exp_q.push_back(m_cs);
`endif
            end
            if (active) m_exp_g = N'(1) << pkt_ch;
            check_val("grant", src_grant, m_exp_g);
            m_cur_idle = !active;

            if (prev_wr && prev_wait) begin
                check_val("stall_write", avm_write, 1);
                check_val("stall_wdata", avm_writedata, prev_data);
                check_val("stall_addr", avm_address, prev_addr);
            end
            if (!avm_write) check_val("idle_addr", avm_address, 0);
            check_val("ready_scope", src_ready & ~src_grant, 0);

            for (int s = 0; s < N; s++) begin
                if (src_ready[s] && src_valid[s]) begin
                    check_val("over_accept", 32'(pend[s] && idx[s] <= len_m[s]), 1);
                    idx[s]++;
                end
            end

            m_sent = avm_write && !avm_waitrequest;
            if (m_sent) begin
                if (exp_q.size() == 0) begin
                    check_val("stray_write", avm_write, 0);
                end else begin
                    m_b = exp_q.pop_front();
                    check_val("wdata", avm_writedata, {24'h0, m_b});
                    check_val("waddr", avm_address, 1);
                    if (nostall) check_val("b2b_timing", 32'(cyc - start_cyc), 32'(pos));
                    if (pos == 2 && stall_arm) begin stall_cnt = 5; stall_arm = 0; end
                    if (pos == 3 && vgap_arm) begin vgap_cnt = 3; vgap_arm = 0; end
                    pos++;
                end
            end

            m_exp_d = (active && m_sent && exp_q.size() == 0) ? (N'(1) << pkt_ch) : '0;
            check_val("done", src_done, m_exp_d);
            if (m_exp_d != '0) begin
                active = 0;
                rr_m = (pkt_ch + 1) % N;
                pend[pkt_ch] = 0;
                npk++;
            end

            prev_idle = m_cur_idle;
            req_prev  = src_req;
            prev_wr   = avm_write;
            prev_wait = avm_waitrequest;
            prev_data = avm_writedata;
            prev_addr = avm_address;
        end
    end

    initial begin
        int osz;
        int n;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // two simultaneous zero-length requests, twice: order 0,1,0,1
        nostall = 1; valid_pct = 100; wait_pct = 0;
        @(negedge clk); #1;
        osz = order_q.size();
        start_pkt(0, 0); start_pkt(1, 0);
        wait_pk(npk + 2, 60);
        @(negedge clk); #1;
        start_pkt(0, 0); start_pkt(1, 0);
        wait_pk(npk + 2, 60);
        check_val("rr_order0", 32'(order_q[osz]), 0);
        check_val("rr_order1", 32'(order_q[osz+1]), 1);
        check_val("rr_order2", 32'(order_q[osz+2]), 0);
        check_val("rr_order3", 32'(order_q[osz+3]), 1);

        // single ch0 packet len=1, bytes 11 22, back-to-back
        @(negedge clk); #1;
        start_pkt(0, 1);
        pay[0][0] = 8'h11; pay[0][1] = 8'h22;
        wait_pk(npk + 1, 50);

        // 5-cycle waitrequest on the second payload byte
        nostall = 0;
        @(negedge clk); #1;
        stall_arm = 1;
        start_pkt(1, 5);
        wait_pk(npk + 1, 80);

        // 3-cycle valid gap mid-payload
        @(negedge clk); #1;
        vgap_arm = 1;
        start_pkt(0, 7);
        wait_pk(npk + 1, 80);

        // 256-byte payload, no stalls
        nostall = 1;
        @(negedge clk); #1;
        start_pkt(0, 255);
        wait_pk(npk + 1, 400);

        // len=1 bytes 80 90 (checksum 11 when enabled)
        @(negedge clk); #1;
        start_pkt(1, 1);
        pay[1][0] = 8'h80; pay[1][1] = 8'h90;
        wait_pk(npk + 1, 50);

        // randomized traffic
        nostall = 0; auto_new = 1; drop_en = 1;
        valid_pct = 70; wait_pct = 25; new_pct = 20;
        wait_pk(npk + 60, 30000);
        auto_new = 0;
        n = 0;
        while (any_pend() && n < 5000) begin @(negedge clk); n++; end
        #1;
        check_val("drain", 32'(any_pend()), 0);

        // asynchronous reset in the middle of a ch0 payload
        drop_en = 0; valid_pct = 100; wait_pct = 0;
        @(negedge clk); #1;
        start_pkt(0, 40); start_pkt(1, 3);
        n = 0;
        while (!(active && pkt_ch == 0 && pos >= 5) && n < 200) begin
            @(negedge clk); #1; n++;
        end
        check_val("reach_data", 32'(active && pkt_ch == 0 && pos >= 5), 1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        start_pkt(1, 3); start_pkt(0, 2);
        osz = order_q.size();
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        wait_pk(npk + 2, 100);
        check_val("post_rst_first", (order_q.size() > osz) ? 32'(order_q[osz]) : 32'hFFFF, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
